// File: rtl/simon_tone_sequencer.sv
// simon_tone_sequencer
//
// Purpose:
//   Plays a Simon colour pattern through the tone generator. For each step it
//   drives the tone frequency and lights the matching LED for TONE_CYCLES
//   cycles, then stays silent for GAP_CYCLES cycles. When idle it plays the
//   tone of the lowest-numbered player key held. A frequency of 0 means silence.
//
// Ports:
//   FPGA_CLK1_50       in   1         clock, rising edge
//   reset_n            in   1         asynchronous active-low reset
//   start              in   1         single-cycle request to play the pattern
//   pattern            in   2*MAX_LEN colour codes, step i = pattern[2i+1:2i]
//   length             in   LEN_W     number of steps (clamped to MAX_LEN)
//   key                in   4         player keys, bit i selects colour i
//   desired_frequency  out  32        tone generator frequency, 0 = silent
//   led                out  4         one-hot lit colour, 0 = none
//   busy               out  1         playback in progress
//   done               out  1         one-cycle pulse when playback completes
//
// Colour codes: 0 green, 1 red, 2 yellow, 3 blue.

module simon_tone_sequencer #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TONE_CYCLES = 20_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int MAX_LEN     = 16,
    parameter int FREQ0       = 415,
    parameter int FREQ1       = 310,
    parameter int FREQ2       = 252,
    parameter int FREQ3       = 209,
    localparam int LEN_W      = $clog2(MAX_LEN + 1),
    localparam int IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                   FPGA_CLK1_50,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [2*MAX_LEN-1:0]   pattern,
    input  logic [LEN_W-1:0]       length,
    input  logic [3:0]             key,
    output logic [31:0]            desired_frequency,
    output logic [3:0]             led,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [31:0] TONE_LAST = 32'(TONE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

    state_t                 r_state;
    logic [2*MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]       r_len;
    logic [IDX_W-1:0]       r_idx;
    logic [31:0]            r_cnt;
    logic [31:0]            r_freq;
    logic [3:0]             r_led;
    logic                   r_busy;
    logic                   r_done;

    logic [1:0]             w_codes [MAX_LEN];
    logic [LEN_W-1:0]       w_clamped_len;
    logic [IDX_W-1:0]       w_next_idx;
    logic                   w_more;
    logic [31:0]            w_key_freq;
    logic [3:0]             w_key_led;

    function automatic logic [31:0] freq_of(input logic [1:0] code);
        case (code)
            2'd0:    freq_of = 32'(FREQ0);
            2'd1:    freq_of = 32'(FREQ1);
            2'd2:    freq_of = 32'(FREQ2);
            default: freq_of = 32'(FREQ3);
        endcase
    endfunction

    function automatic logic [3:0] onehot_of(input logic [1:0] code);
        onehot_of = 4'b0001 << code;
    endfunction

    // Split the latched pattern into per-step colour codes.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_codes
            assign w_codes[gi] = r_pattern[2*gi +: 2];
        end
    endgenerate

    assign w_clamped_len = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
    assign w_next_idx    = r_idx + 1'b1;
    // Compare in the wider length domain so index+1 cannot wrap.
    assign w_more        = (LEN_W'(r_idx) + LEN_W'(1)) < r_len;

    // Idle key play: the lowest set key bit wins.
    always_comb begin
        w_key_freq = '0;
        w_key_led  = '0;
        if (key[0]) begin
            w_key_freq = freq_of(2'd0);
            w_key_led  = onehot_of(2'd0);
        end else if (key[1]) begin
            w_key_freq = freq_of(2'd1);
            w_key_led  = onehot_of(2'd1);
        end else if (key[2]) begin
            w_key_freq = freq_of(2'd2);
            w_key_led  = onehot_of(2'd2);
        end else if (key[3]) begin
            w_key_freq = freq_of(2'd3);
            w_key_led  = onehot_of(2'd3);
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_freq    <= '0;
            r_led     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pattern <= pattern;
                        r_len     <= w_clamped_len;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                        if (w_clamped_len == '0) begin
                            // Empty pattern: report completion, leave the
                            // outputs exactly as they were.
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_TONE;
                            r_busy  <= 1'b1;
                            r_freq  <= freq_of(pattern[1:0]);
                            r_led   <= onehot_of(pattern[1:0]);
                        end
                    end else begin
                        r_freq <= w_key_freq;
                        r_led  <= w_key_led;
                    end
                end

                S_TONE: begin
                    if (r_cnt == TONE_LAST) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        r_freq  <= '0;
                        r_led   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (w_more) begin
                            r_idx   <= w_next_idx;
                            r_state <= S_TONE;
                            r_freq  <= freq_of(w_codes[w_next_idx]);
                            r_led   <= onehot_of(w_codes[w_next_idx]);
                        end else begin
                            // Outputs stay silent here; key play resumes on
                            // the following edge from IDLE.
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_freq  <= '0;
                    r_led   <= '0;
                end
            endcase
        end
    end

    assign desired_frequency = r_freq;
    assign led               = r_led;
    assign busy              = r_busy;
    assign done              = r_done;

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Testbench for simon_tone_sequencer with a short tone/gap configuration.
// A driver applies one set of inputs per cycle and pushes the expected
// outputs for the following cycle (tagged with that cycle number) into a
// queue; a monitor on the falling edge pops and compares.

module tb_simon_tone_sequencer;

    localparam int TONE    = 10;
    localparam int GAP     = 4;
    localparam int MAXL    = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pattern = '0;
    logic [4:0]  length = '0;
    logic [3:0]  key = 4'b0001;
    logic [31:0] desired_frequency;
    logic [3:0]  led;
    logic        busy;
    logic        done;

    simon_tone_sequencer #(
        .TONE_CYCLES(TONE),
        .GAP_CYCLES (GAP),
        .MAX_LEN    (MAXL)
    ) dut (
        .FPGA_CLK1_50     (clk),
        .reset_n          (reset_n),
        .start            (start),
        .pattern          (pattern),
        .length           (length),
        .key              (key),
        .desired_frequency(desired_frequency),
        .led              (led),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] f;
        logic [3:0]  l;
        logic        b;
        logic        d;
    } exp_t;

    exp_t exp_q[$];
    exp_t plan[$];
    exp_t last;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fin = 1'b0;
    int   freq_tbl [4] = '{415, 310, 252, 209};

    always @(posedge clk) cyc++;

    // Reference model: from idle, a start schedules the whole playback as a
    // list of per-cycle outputs; while that list is non-empty inputs are moot.
    task automatic apply_and_model(input logic st, input logic [31:0] pat,
                                   input logic [4:0] len, input logic [3:0] k);
        exp_t e;
        int   n;
        int   steps;
        logic [31:0] p;
        start = st; pattern = pat; length = len; key = k;
        e = '{cyc: 0, f: 32'd0, l: 4'd0, b: 1'b0, d: 1'b0};
        if (plan.size() > 0) begin
            e = plan.pop_front();
        end else if (st) begin
            steps = (int'(len) > MAXL) ? MAXL : int'(len);
            if (steps == 0) begin
                e = last;
                e.b = 1'b0;
                e.d = 1'b1;
            end else begin
                p = pat;
                for (int s = 0; s < steps; s++) begin
                    n = int'(p[1:0]);
                    p = p >> 2;
                    for (int t = 0; t < TONE; t++)
                        plan.push_back('{cyc: 0, f: 32'(freq_tbl[n]), l: 4'(1 << n), b: 1'b1, d: 1'b0});
                    for (int g = 0; g < GAP; g++)
                        plan.push_back('{cyc: 0, f: 32'd0, l: 4'd0, b: 1'b1, d: 1'b0});
                end
                plan.push_back('{cyc: 0, f: 32'd0, l: 4'd0, b: 1'b0, d: 1'b1});
                e = plan.pop_front();
            end
        end else begin
            n = -1;
            for (int i = 3; i >= 0; i--) if (k[i]) n = i;
            if (n >= 0) begin
                e.f = 32'(freq_tbl[n]);
                e.l = 4'(1 << n);
            end
        end
        e.cyc = cyc + 1;
        last = e;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic [31:0] pat,
                         input logic [4:0] len, input logic [3:0] k);
        @(posedge clk);
        #1;
        apply_and_model(st, pat, len, k);
    endtask

    task automatic idle_cycles(input int n, input logic [3:0] k);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 5'($urandom), k);
    endtask

    // Monitor: sole owner of the check counters.
    always begin : monitor
        exp_t e;
        @(negedge clk or negedge reset_n);
        if (!reset_n) begin
            #1;
            exp_q.delete();
            checks++;
            if (desired_frequency !== 32'd0 || led !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs t=%0t freq=%0d led=%b busy=%b done=%b required all zero",
                         $time, desired_frequency, led, busy, done);
            end
        end else if (fin) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain pending=%0d required 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (desired_frequency !== e.f || led !== e.l || busy !== e.b || done !== e.d) begin
                errors++;
                $display("FAIL output cyc=%0d freq=%0d led=%b busy=%b done=%b required freq=%0d led=%b busy=%b done=%b",
                         cyc, desired_frequency, led, busy, done, e.f, e.l, e.b, e.d);
            end
        end
    end

    initial begin
        last = '{cyc: 0, f: 32'd0, l: 4'd0, b: 1'b0, d: 1'b0};

        // Reset held with key 0001: outputs must stay 0; key play right after.
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply_and_model(1'b0, 32'd0, 5'd0, 4'b0001);
        idle_cycles(3, 4'b0001);

        // Directed pattern {2,0,3}.
        drive(1'b1, 32'h0000_0032, 5'd3, 4'b0000);
        idle_cycles(50, 4'b0000);

        // Same again, with a restart attempt and new pattern during step 1.
        drive(1'b1, 32'h0000_0032, 5'd3, 4'b0000);
        idle_cycles(16, 4'b0000);
        drive(1'b1, 32'hFFFF_FFFF, 5'd5, 4'b0010);
        idle_cycles(30, 4'b0100);

        // Length 0 with no key, then with a key tone already sounding.
        drive(1'b1, 32'h0000_0003, 5'd0, 4'b0000);
        idle_cycles(3, 4'b0000);
        idle_cycles(2, 4'b0100);
        drive(1'b1, 32'h0000_0003, 5'd0, 4'b0100);
        idle_cycles(3, 4'b0000);

        // Over-long length clamps to MAX_LEN steps.
        drive(1'b1, $urandom, 5'(MAXL + 5), 4'b0000);
        idle_cycles(MAXL * (TONE + GAP) + 5, 4'b0000);

        // Start and key on the same cycle: start wins.
        drive(1'b1, 32'h0000_0003, 5'd1, 4'b0110);
        idle_cycles(20, 4'b0110);
        idle_cycles(2, 4'b0000);

        // Randomized traffic.
        for (int i = 0; i < 500; i++)
            drive(($urandom_range(0, 7) == 0), $urandom, 5'($urandom_range(0, 20)),
                  ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom));
        while (plan.size() > 0) drive(1'b0, $urandom, 5'd0, 4'b0000);

        // Reset mid-tone at step 1 of 3, then a fresh playback.
        drive(1'b1, 32'h0000_0039, 5'd3, 4'b0000);
        idle_cycles(TONE + GAP + 3, 4'b0000);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        plan.delete();
        last = '{cyc: 0, f: 32'd0, l: 4'd0, b: 1'b0, d: 1'b0};
        apply_and_model(1'b0, 32'd0, 5'd0, 4'b0000);
        idle_cycles(3, 4'b0000);
        drive(1'b1, 32'($urandom), 5'd3, 4'($urandom));
        idle_cycles(3 * (TONE + GAP) + 6, 4'b1000);

        repeat (2) @(posedge clk);
        fin = 1'b1;
    end

endmodule

// File: doc/simon_tone_sequencer.md
# simon_tone_sequencer

Plays a Simon color pattern through the tone generator: for each step it drives the tone frequency and lights the matching LED for a fixed tone time, then a silent gap. When idle it plays the tone for whichever player key is held. It sits between game control and the tone generator, whose frequency input it drives, with 0 meaning silence.

## Interface
- CLK_HZ, 50_000_000: clock rate; documentation only, the durations below are in cycles.
- TONE_CYCLES, 20_000_000: tone length per step (400 ms).
- GAP_CYCLES, 5_000_000: silent gap after each step (100 ms).
- MAX_LEN, 16: maximum steps per pattern.
- FREQ0 / FREQ1 / FREQ2 / FREQ3, 415 / 310 / 252 / 209: Hz values for green / red / yellow / blue (color codes 0..3).

- FPGA_CLK1_50  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to play the pattern.
- pattern  in  2*MAX_LEN  color codes; step i is pattern[2i+1:2i], step 0 plays first.
- length  in  $clog2(MAX_LEN+1)  number of steps to play.
- key  in  4  player keys; bit i selects color i.
- desired_frequency  out  32  frequency to the tone generator; 0 means silent.
- led  out  4  one-hot lit color; 0 means no LED lit.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse when playback completes.

## Operation
- States: IDLE, TONE, GAP.
- IDLE:
  - start=1 latches pattern and length, clamps length to MAX_LEN, clears the step index and the duration counter.
  - If the clamped length is 0: stay in IDLE, pulse done next cycle, busy stays 0.
  - Otherwise go to TONE.
- IDLE key play (when start=0):
  - Lowest set key bit wins.
  - desired_frequency = FREQn and led = one-hot(n).
  - With no key held, both outputs are 0.
- TONE:
  - desired_frequency = FREQ[code], led = one-hot(code), code = latched pattern step at the current index.
  - After TONE_CYCLES cycles in TONE, go to GAP.
- GAP:
  - desired_frequency = 0, led = 0.
  - After GAP_CYCLES cycles, increment the index. If index+1 < length, go to TONE; else go to IDLE and pulse done.
- busy = 1 in TONE and GAP.
- While busy: start and key are ignored; pattern and length may change freely because latched copies are used.
- The duration counter is 32 bits. It is cleared on each state entry and compared against TONE_CYCLES-1 or GAP_CYCLES-1.
- TONE_CYCLES and GAP_CYCLES must be ≥1.
- GAP_CYCLES=0 is illegal.

## Timing
- All outputs are registered.
- Reset values: desired_frequency=0, led=0, busy=0, done=0, state IDLE, index 0.
- Reset asserted at any time forces these values immediately (asynchronously) and silences any tone mid-playback.
- Start at edge k:
  - busy=1, desired_frequency/led valid for step 0 from edge k+1.
  - Each step's tone occupies exactly TONE_CYCLES cycles, then exactly GAP_CYCLES silent cycles.
- Total busy cycles = length*(TONE_CYCLES+GAP_CYCLES).
- At the edge ending the last gap: busy→0 and done→1 for one cycle.
  - If a key is held on that edge, key play begins the following cycle, not the same one.
- Key play latency: output follows key with one cycle of latency. Release gives 0 one cycle later.
- Start and key high on the same IDLE cycle: start wins and key is ignored.
- Length 0 start: done=1 on edge k+1; busy, desired_frequency and led unchanged.

## Test plan
- Reset with key=4'b0001 held: all outputs 0 while reset_n=0. After release, desired_frequency=415 and led=0001 one cycle after the first edge.
- TONE_CYCLES=10, GAP_CYCLES=4, pattern steps {2,0,3}, length=3, start pulse:
  - outputs 252/0100 for 10 cycles, 0/0000 for 4 cycles, 415/0001 ×10, 0 ×4, 209/1000 ×10, 0 ×4;
  - busy high 42 cycles, done single pulse on cycle 43, no other done pulses.
- Same config; change pattern and pulse start again at step 1: no effect, sequence identical to the previous case.
- length=0 start: done pulses one cycle later, busy never asserted, desired_frequency stays 0. length=MAX_LEN+5: exactly MAX_LEN steps are played.
- key=4'b0110: desired_frequency=310 and led=0010. In the same cycle as this key press, a start with length=1 and code 3 plays 209 and ignores the key.
- Assert reset_n=0 mid-TONE at step 1 of 3: outputs go to 0 immediately. After release the block is IDLE, no done pulse occurs, and a new start plays from step 0.
